// File: rtl/dvi_pkg.sv
// -----------------------------------------------------------------------------
// dvi_pkg
// Shared definitions for the DVI raster sequencer:
//   - 640x480@60 timing constants (used as parameter defaults)
//   - FSM state encoding for the run/stop control
//   - helper that sums the four regions of one axis into its total length
// -----------------------------------------------------------------------------
package dvi_pkg;

   // 640x480@60 horizontal timing (pixels)
   localparam int C_H_ACTIVE = 640;
   localparam int C_H_FP     = 16;
   localparam int C_H_SYNC   = 96;
   localparam int C_H_BP     = 48;

   // 640x480@60 vertical timing (lines)
   localparam int C_V_ACTIVE = 480;
   localparam int C_V_FP     = 10;
   localparam int C_V_SYNC   = 2;
   localparam int C_V_BP     = 33;

   // Counter and coordinate width
   localparam int C_CW       = 12;

   // Run/stop control states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_STOP = 2'd2
   } state_t;

   // Length of one axis: active + front porch + sync + back porch
   function automatic int axis_total(input int active, input int fp,
                                     input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/dvi_timing_axis.sv
// -----------------------------------------------------------------------------
// dvi_timing_axis
// Single-axis raster counter (used once for columns, once for lines).
// The count runs 0 .. TOTAL-1 and wraps, advancing only when inc is high.
//
// Ports:
//   clk     in  1   clock
//   rst_n   in  1   synchronous active-low reset
//   inc     in  1   advance the count this cycle
//   clr     in  1   force the count to 0 (wins over inc)
//   cnt     out CW  current position on this axis
//   wrap    out 1   inc is high while at the last position (count returns to 0)
//   active  out 1   position is inside the visible region
//   sync    out 1   position is inside the sync pulse
// -----------------------------------------------------------------------------
module dvi_timing_axis
   import dvi_pkg::*;
#(
   parameter int ACTIVE = C_H_ACTIVE,
   parameter int FP     = C_H_FP,
   parameter int SYNC   = C_H_SYNC,
   parameter int BP     = C_H_BP,
   parameter int CW     = C_CW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   input  logic          clr,
   output logic [CW-1:0] cnt,
   output logic          wrap,
   output logic          active,
   output logic          sync
);

   localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

   // Region boundaries pre-sized to the counter width so every compare is
   // between equal-width unsigned values.
   localparam logic [CW-1:0] L_LAST       = CW'(TOTAL - 1);
   localparam logic [CW-1:0] L_ACTIVE     = CW'(ACTIVE);
   localparam logic [CW-1:0] L_SYNC_FIRST = CW'(ACTIVE + FP);
   localparam logic [CW-1:0] L_SYNC_LAST  = CW'(ACTIVE + FP + SYNC - 1);

   logic [CW-1:0] r_cnt;
   logic          w_at_last;

   assign w_at_last = (r_cnt == L_LAST);

   // NOTE: sequential state is written with non-blocking assignments so every
   // flop samples the pre-edge values regardless of block ordering; reset is
   // sampled on the clock edge, not in the sensitivity list.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         r_cnt <= '0;
      end else if (inc) begin
         r_cnt <= w_at_last ? '0 : r_cnt + CW'(1);
      end
   end

   assign cnt    = r_cnt;
   assign wrap   = inc && w_at_last;
   assign active = (r_cnt < L_ACTIVE);
   assign sync   = (r_cnt >= L_SYNC_FIRST) && (r_cnt <= L_SYNC_LAST);

endmodule

// File: rtl/dvi_video_timing.sv
// -----------------------------------------------------------------------------
// dvi_video_timing
// Raster sequencer for the DVI output path. Walks horizontal/vertical counters
// through active, porch and sync regions, requests each visible pixel one
// cycle ahead of data-enable, and drives de/hsync/vsync toward the TMDS
// encoders. Starting and stopping happen only on frame boundaries.
//
// Ports:
//   pix_clk      in  1   pixel clock (only clock)
//   rst_n        in  1   synchronous active-low reset
//   en           in  1   run request, sampled every cycle
//   pix_req      out 1   pixel at (pix_x,pix_y) needed; data expected next cycle
//   pix_x        out CW  column of requested pixel (holds while pix_req=0)
//   pix_y        out CW  row of requested pixel (holds while pix_req=0)
//   frame_start  out 1   pulse coinciding with the request for pixel (0,0)
//   de           out 1   data enable (pix_req delayed by one cycle)
//   hsync        out 1   horizontal sync, active level HS_POL
//   vsync        out 1   vertical sync, active level VS_POL
//   running      out 1   sequencer is not idle
//
// Pipeline for a counter value (h,v) present in cycle t:
//   t+1 : pix_req / pix_x / pix_y / frame_start      (stage 1)
//   t+2 : de / hsync / vsync                         (stage 2)
// -----------------------------------------------------------------------------
module dvi_video_timing
   import dvi_pkg::*;
#(
   parameter int   H_ACTIVE = C_H_ACTIVE,
   parameter int   H_FP     = C_H_FP,
   parameter int   H_SYNC   = C_H_SYNC,
   parameter int   H_BP     = C_H_BP,
   parameter int   V_ACTIVE = C_V_ACTIVE,
   parameter int   V_FP     = C_V_FP,
   parameter int   V_SYNC   = C_V_SYNC,
   parameter int   V_BP     = C_V_BP,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   CW       = C_CW
) (
   input  logic          pix_clk,
   input  logic          rst_n,
   input  logic          en,
   output logic          pix_req,
   output logic [CW-1:0] pix_x,
   output logic [CW-1:0] pix_y,
   output logic          frame_start,
   output logic          de,
   output logic          hsync,
   output logic          vsync,
   output logic          running
);

   // ---------------------------------------------------------------- control
   state_t r_state;
   state_t w_next_state;
   logic   r_running;

   // Counter interface
   logic          w_count_en;
   logic          w_clr;
   logic [CW-1:0] w_h_cnt;
   logic [CW-1:0] w_v_cnt;
   logic          w_h_wrap;
   logic          w_v_wrap;
   logic          w_h_active;
   logic          w_v_active;
   logic          w_h_sync;
   logic          w_v_sync;

   // Stage 1 registers
   logic          r_pix_req;
   logic [CW-1:0] r_pix_x;
   logic [CW-1:0] r_pix_y;
   logic          r_frame_start;
   logic          r_hs_s1;
   logic          r_vs_s1;

   // Stage 2 registers
   logic          r_de;
   logic          r_hsync;
   logic          r_vsync;

   // Counters advance in RUN and STOP and sit at (0,0) while idle, so the
   // first counted cycle after leaving IDLE is always (0,0).
   assign w_count_en = (r_state != S_IDLE);
   assign w_clr      = (r_state == S_IDLE);

   // The vertical wrap only fires on the final pixel of the final line, so it
   // doubles as the "last count of the frame" flag.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (en) w_next_state = S_RUN;
         end
         S_RUN: begin
            if (!en) w_next_state = S_STOP;
         end
         S_STOP: begin
            if (en)            w_next_state = S_RUN;
            else if (w_v_wrap) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // running is registered from the next state, so it rises together with
   // the RUN state and one cycle ahead of the first frame_start.
   always_ff @(posedge pix_clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_running <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_running <= (w_next_state != S_IDLE);
      end
   end

   // --------------------------------------------------------------- counters
   dvi_timing_axis #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .CW     (CW)
   ) u_h_axis (
      .clk    (pix_clk),
      .rst_n  (rst_n),
      .inc    (w_count_en),
      .clr    (w_clr),
      .cnt    (w_h_cnt),
      .wrap   (w_h_wrap),
      .active (w_h_active),
      .sync   (w_h_sync)
   );

   dvi_timing_axis #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .CW     (CW)
   ) u_v_axis (
      .clk    (pix_clk),
      .rst_n  (rst_n),
      .inc    (w_h_wrap),
      .clr    (w_clr),
      .cnt    (w_v_cnt),
      .wrap   (w_v_wrap),
      .active (w_v_active),
      .sync   (w_v_sync)
   );

   // ---------------------------------------------------------------- stage 1
   // All region flags are gated by w_count_en: while idle the counters read
   // (0,0), which would otherwise decode as the first visible pixel.
   always_ff @(posedge pix_clk) begin
      if (!rst_n) begin
         r_pix_req     <= 1'b0;
         r_pix_x       <= '0;
         r_pix_y       <= '0;
         r_frame_start <= 1'b0;
         r_hs_s1       <= 1'b0;
         r_vs_s1       <= 1'b0;
      end else begin
         r_pix_req     <= w_count_en && w_h_active && w_v_active;
         r_frame_start <= w_count_en && (w_h_cnt == '0) && (w_v_cnt == '0);
         r_hs_s1       <= w_count_en && w_h_sync;
         r_vs_s1       <= w_count_en && w_v_sync;
         // Coordinates only move with a request so the pixel source sees a
         // stable address between lines.
         if (w_count_en && w_h_active && w_v_active) begin
            r_pix_x <= w_h_cnt;
            r_pix_y <= w_v_cnt;
         end
      end
   end

   // ---------------------------------------------------------------- stage 2
   always_ff @(posedge pix_clk) begin
      if (!rst_n) begin
         r_de    <= 1'b0;
         r_hsync <= ~HS_POL;
         r_vsync <= ~VS_POL;
      end else begin
         r_de    <= r_pix_req;
         r_hsync <= r_hs_s1 ? HS_POL : ~HS_POL;
         r_vsync <= r_vs_s1 ? VS_POL : ~VS_POL;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign pix_req     = r_pix_req;
   assign pix_x       = r_pix_x;
   assign pix_y       = r_pix_y;
   assign frame_start = r_frame_start;
   assign de          = r_de;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign running     = r_running;

endmodule
